// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a one-entry skid buffer so in_ready comes
// straight from a flop; flush squashes both held entries.
module ex_mem_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_res,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic [31:0] out_wdata,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        fwd_valid
);

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] pc;
    } bundle_t;

    bundle_t main_q, main_d, skid_q, skid_d, in_bundle;
    logic    main_valid_q, main_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    accept, drain;

    assign in_bundle = '{res:       in_res,
                         wdata:     in_wdata,
                         rd:        in_rd,
                         reg_write: in_reg_write,
                         mem_read:  in_mem_read,
                         mem_write: in_mem_write,
                         pc:        in_pc};

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Payload is left stale; outputs are gated by the valid bit.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (accept) begin
                        main_d       = in_bundle;
                        main_valid_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (drain && accept) begin
                        main_d = in_bundle;
                    end else if (drain) begin
                        main_valid_d = 1'b0;
                    end else if (accept) begin
                        skid_d       = in_bundle;
                        skid_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (drain) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    // Unreachable occupancy; recover to empty.
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid     = main_valid_q;
    assign out_res       = main_q.res;
    assign out_wdata     = main_q.wdata;
    assign out_pc        = main_q.pc;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write & main_valid_q;
    assign out_mem_read  = main_q.mem_read & main_valid_q;
    assign out_mem_write = main_q.mem_write & main_valid_q;
    assign fwd_valid     = out_reg_write & (|main_q.rd);

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed self-checking bench for ex_mem_skid; inputs driven and outputs
// sampled on the falling clock edge.
module tb_ex_mem_skid;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_res;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [31:0] out_wdata;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        fwd_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ex_mem_skid dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_res       (in_res),
        .in_wdata     (in_wdata),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_wdata    (out_wdata),
        .out_pc       (out_pc),
        .out_rd       (out_rd),
        .out_reg_write(out_reg_write),
        .out_mem_read (out_mem_read),
        .out_mem_write(out_mem_write),
        .fwd_valid    (fwd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // wdata and pc are derived from res so every field is checkable.
    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw);
        in_valid     = v;
        in_res       = res;
        in_wdata     = ~res;
        in_pc        = res + 32'h0000_0400;
        in_rd        = rd;
        in_reg_write = rw;
        in_mem_read  = mr;
        in_mem_write = mw;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_res !== 32'h0) $display("FAIL reset_out_res got %h want 0", out_res);
        else pass_cnt++;
        total_cnt++;
        if (out_pc !== 32'h0) $display("FAIL reset_out_pc got %h want 0", out_pc);
        else pass_cnt++;
        total_cnt++;
        if (fwd_valid !== 1'b0) $display("FAIL reset_fwd_valid got %b want 0", fwd_valid);
        else pass_cnt++;
    endtask

    task automatic test_streaming;
        logic [31:0] exp;
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            exp = 32'(i);
            drive(1'b1, exp, 5'd3, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || out_res !== exp)
                $display("FAIL stream_%0d got valid=%b res=%h want valid=1 res=%h",
                         i, out_valid, out_res, exp);
            else pass_cnt++;
            total_cnt++;
            if (out_wdata !== ~exp || out_pc !== exp + 32'h400 || in_ready !== 1'b1)
                $display("FAIL stream_fields_%0d got wdata=%h pc=%h rdy=%b want %h %h 1",
                         i, out_wdata, out_pc, in_ready, ~exp, exp + 32'h400);
            else pass_cnt++;
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL stream_drained got %b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_res !== 32'hA || in_ready !== 1'b1)
            $display("FAIL bp_load_a got valid=%b res=%h rdy=%b want 1 a 1",
                     out_valid, out_res, in_ready);
        else pass_cnt++;
        drive(1'b1, 32'hB, 5'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (out_res !== 32'hA || in_ready !== 1'b0)
            $display("FAIL bp_skid_b got res=%h rdy=%b want a 0", out_res, in_ready);
        else pass_cnt++;
        drive(1'b1, 32'hC, 5'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_res !== 32'hA || in_ready !== 1'b0)
            $display("FAIL bp_hold got valid=%b res=%h rdy=%b want 1 a 0",
                     out_valid, out_res, in_ready);
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_res !== 32'hB || in_ready !== 1'b1)
            $display("FAIL bp_out_b got valid=%b res=%h rdy=%b want 1 b 1",
                     out_valid, out_res, in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_res !== 32'hC)
            $display("FAIL bp_out_c got valid=%b res=%h want 1 c", out_valid, out_res);
        else pass_cnt++;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_drained got %b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 5'd4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h20, 5'd4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0 || out_res !== 32'h10)
            $display("FAIL flush_setup got rdy=%b res=%h want 0 10", in_ready, out_res);
        else pass_cnt++;
        drive(1'b1, 32'h30, 5'd4, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_full got valid=%b rdy=%b want 0 1", out_valid, in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_reg_write !== 1'b0 || fwd_valid !== 1'b0)
            $display("FAIL flush_gating got rw=%b fwd=%b want 0 0", out_reg_write, fwd_valid);
        else pass_cnt++;
        // Flush while empty with a live accept: the accept must be dropped.
        drive(1'b1, 32'h40, 5'd4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL flush_accept got valid=%b want 0", out_valid);
        else pass_cnt++;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b0)
                $display("FAIL flush_no_leak got valid=%b res=%h want 0", out_valid, out_res);
            else pass_cnt++;
        end
    endtask

    task automatic test_forwarding;
        out_ready = 1'b0;
        drive(1'b1, 32'h50, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || fwd_valid !== 1'b0)
            $display("FAIL fwd_rd0 got valid=%b fwd=%b want 1 0", out_valid, fwd_valid);
        else pass_cnt++;
        out_ready = 1'b1;
        drive(1'b1, 32'h51, 5'd8, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (fwd_valid !== 1'b1 || out_rd !== 5'd8 || out_mem_read !== 1'b1)
            $display("FAIL fwd_rd8 got fwd=%b rd=%0d mr=%b want 1 8 1",
                     fwd_valid, out_rd, out_mem_read);
        else pass_cnt++;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (fwd_valid !== 1'b1 || out_res !== 32'h51)
            $display("FAIL fwd_held got fwd=%b res=%h want 1 51", fwd_valid, out_res);
        else pass_cnt++;
        out_ready = 1'b1;
        drive(1'b1, 32'h52, 5'd8, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || fwd_valid !== 1'b0 || out_mem_write !== 1'b1)
            $display("FAIL fwd_norw got valid=%b fwd=%b mw=%b want 1 0 1",
                     out_valid, fwd_valid, out_mem_write);
        else pass_cnt++;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        drive(1'b1, 32'h60, 5'd9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h70, 5'd9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL arst_setup got rdy=%b valid=%b want 0 1", in_ready, out_valid);
        else pass_cnt++;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || fwd_valid !== 1'b0)
            $display("FAIL arst_immediate got valid=%b rdy=%b fwd=%b want 0 1 0",
                     out_valid, in_ready, fwd_valid);
        else pass_cnt++;
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b0 || out_res !== 32'h0)
                $display("FAIL arst_no_old got valid=%b res=%h want 0 0", out_valid, out_res);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_forwarding();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
# ex_mem_skid

Registered EX→MEM pipeline boundary for the 32-bit MIPS-style core. It captures the execute-stage result bundle: the ALU/shifter result (including the logical-right-shift output), store data, destination register, control bits and PC. It presents that bundle to the memory stage behind a valid/ready handshake. A one-entry skid buffer lets EX see backpressure from a registered `in_ready`, so no combinational ready path crosses the stage. A flush input squashes both entries on branch/exception redirect.

## Interface
Parameters: none; all widths fixed by the 32-bit datapath.

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  squash all held entries this cycle
- `in_valid`  in  1  EX bundle valid
- `in_ready`  out  1  stage can accept; registered (equals !skid_valid)
- `in_res`  in  32  ALU/shift result
- `in_wdata`  in  32  store data (rt value)
- `in_rd`  in  5  destination register
- `in_reg_write`, `in_mem_read`, `in_mem_write`  in  1 each  control bits
- `in_pc`  in  32  instruction PC
- `out_valid`  out  1  MEM bundle valid
- `out_ready`  in  1  MEM stage accepts
- `out_res`, `out_wdata`, `out_pc`  out  32 each  registered payload
- `out_rd`  out  5  registered destination register
- `out_reg_write`, `out_mem_read`, `out_mem_write`  out  1 each  registered control bits
- `fwd_valid`  out  1  = out_valid & out_reg_write & (out_rd != 0); forwarding qualifier for EX

## Operation
- Storage: main register (drives outputs) plus skid register, each with its own valid bit. Four occupancy states: EMPTY (main 0, skid 0), ONE (main 1, skid 0), FULL (main 1, skid 1). The state main 0, skid 1 is illegal and never entered.
- Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
- EMPTY: on accept, load main → ONE.
- ONE, drain & accept: load main with input; stay ONE.
- ONE, drain only → EMPTY.
- ONE, accept only (MEM stalled): load skid → FULL. `in_ready` falls next cycle.
- ONE, neither: hold.
- FULL, drain: move skid to main, clear skid → ONE. `in_ready` can never be high in FULL, so there is no simultaneous accept.
- FULL, no drain: hold both.
- Flush has top priority. It clears both valid bits at the edge, and any accept in the same cycle is discarded. Payload registers may keep stale values, but all `out_*` control bits are gated to 0 while `out_valid` = 0.
- Payload is passed unmodified; no arithmetic. `out_rd` = 0 with reg_write set is legal but never asserts `fwd_valid`.
- Ordering is strictly FIFO. No bundle is duplicated or dropped except by flush.

## Timing
- Reset (async assert, sync release): main/skid valid = 0, so `out_valid` = 0, `in_ready` = 1, `fwd_valid` = 0. All payload outputs = 0.
- Latency: 1 cycle from accept edge to `out_valid` high with the same payload.
- Throughput: 1 bundle/cycle while `out_ready` = 1.
- `in_ready` is a flop output. It deasserts the cycle after the skid fills and reasserts the cycle after the skid drains or a flush.
- `out_*` payload stays stable while `out_valid & !out_ready`.
- Reset asserted mid-transfer: both entries are lost immediately and asynchronously.

## Test plan
- Reset: hold `rst_n` = 0, then release → `out_valid` = 0, `in_ready` = 1, `out_res` = 0, `fwd_valid` = 0.
- Streaming: `out_ready` = 1, inject res = 0x00000001..0x00000005 on consecutive cycles → each appears one cycle later, in order, with no gaps.
- Backpressure: `out_ready` = 0, inject res 0xA, 0xB, 0xC.
  - 0xA → main, 0xB → skid, then `in_ready` = 0 and 0xC is held by EX.
  - Raise `out_ready` → outputs 0xA, 0xB, 0xC in order.
- Flush while FULL (0x10 main, 0x20 skid) with `in_valid` = 1 carrying 0x30 → next cycle `out_valid` = 0, `in_ready` = 1, and 0x30 is never output.
- Forwarding qualifier:
  - bundle rd = 0, reg_write = 1 → `fwd_valid` = 0.
  - rd = 8, reg_write = 1 → `fwd_valid` = 1 while held.
  - rd = 8, reg_write = 0 → `fwd_valid` = 0.
- Async reset mid-stall (FULL, `out_ready` = 0): pulse `rst_n` low between edges → `out_valid` drops immediately, `in_ready` = 1, no old payload emerges afterward.
